rc4_phase_scheduler: RTL and testbench

- Top-level sequencer for the RC4 key-search datapath.
- Runs three engines in a fixed order (S-array init, key-schedule swap, decrypt/check) against one shared single-port 256x8 S memory.
- Grants the memory to exactly one engine at a time.
- On a failed decrypt check, advances the 24-bit key and restarts the whole sequence until the key is found or the key space is exhausted.

---
 rtl/rc4_phase_scheduler_if.sv | 43 ++++
 rtl/rc4_phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_rc4_phase_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_phase_scheduler_if.sv
//------------------------------------------------------------------------------
// Module : rc4_phase_scheduler_if
// Brief  : Engine handshake, engine memory ports and S-memory bus of the RC4 phase scheduler.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rc4_phase_scheduler_if #(
   parameter int KEY_W = 24
);
   logic             go;
   logic [KEY_W-1:0] key;
   logic             init_start, ksa_start, dec_start;
   logic             init_done, ksa_done, dec_done;
   logic             dec_ok;
   logic [7:0]       init_addr, init_data;
   logic [7:0]       ksa_addr, ksa_data;
   logic [7:0]       dec_addr, dec_data;
   logic             init_wren, ksa_wren, dec_wren;
   logic [7:0]       mem_addr, mem_data;
   logic             mem_wren;
   logic             busy, found, fail;

   modport master (
      input  go, init_done, ksa_done, dec_done, dec_ok,
             init_addr, init_data, init_wren,
             ksa_addr, ksa_data, ksa_wren,
             dec_addr, dec_data, dec_wren,
      output key, init_start, ksa_start, dec_start,
             mem_addr, mem_data, mem_wren, busy, found, fail
   );

   modport slave (
      output go, init_done, ksa_done, dec_done, dec_ok,
             init_addr, init_data, init_wren,
             ksa_addr, ksa_data, ksa_wren,
             dec_addr, dec_data, dec_wren,
      input  key, init_start, ksa_start, dec_start,
             mem_addr, mem_data, mem_wren, busy, found, fail
   );
endinterface

`default_nettype wire

// File: rtl/rc4_phase_scheduler.sv
//------------------------------------------------------------------------------
// Module : rc4_phase_scheduler
// Brief  : Sequences init/KSA/decrypt engines over one S memory and steps the key.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rc4_phase_scheduler #(
   parameter int               KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF,
   parameter logic [KEY_W-1:0] KEY_START = 24'h000000
) (
   input wire logic              clk,
   input wire logic              reset,
   rc4_phase_scheduler_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_INIT_GO   = 4'd1,
      S_INIT_WAIT = 4'd2,
      S_KSA_GO    = 4'd3,
      S_KSA_WAIT  = 4'd4,
      S_DEC_GO    = 4'd5,
      S_DEC_WAIT  = 4'd6,
      S_NEXT_KEY  = 4'd7,
      S_FOUND     = 4'd8,
      S_FAIL      = 4'd9
   } state_t;

   state_t           r_state;
   logic [KEY_W-1:0] r_key;
   logic             r_init_start, r_ksa_start, r_dec_start;
   logic             r_busy, r_found, r_fail;
   logic [7:0]       r_mem_addr, r_mem_data;
   logic             r_mem_wren;

   logic             w_owned;
   logic [7:0]       w_addr, w_data;
   logic             w_wren;

   // Done levels are only looked at in the matching WAIT state, so stale levels are harmless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_key        <= KEY_START;
         r_init_start <= 1'b0;
         r_ksa_start  <= 1'b0;
         r_dec_start  <= 1'b0;
         r_busy       <= 1'b0;
         r_found      <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         r_init_start <= 1'b0;
         r_ksa_start  <= 1'b0;
         r_dec_start  <= 1'b0;
         case (r_state)
            S_IDLE, S_FOUND, S_FAIL: begin
               if (bus.go) begin
                  r_key        <= KEY_START;
                  r_found      <= 1'b0;
                  r_fail       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_init_start <= 1'b1;
                  r_state      <= S_INIT_GO;
               end
            end
            S_INIT_GO:   r_state <= S_INIT_WAIT;
            S_INIT_WAIT: begin
               if (bus.init_done) begin
                  r_ksa_start <= 1'b1;
                  r_state     <= S_KSA_GO;
               end
            end
            S_KSA_GO:    r_state <= S_KSA_WAIT;
            S_KSA_WAIT: begin
               if (bus.ksa_done) begin
                  r_dec_start <= 1'b1;
                  r_state     <= S_DEC_GO;
               end
            end
            S_DEC_GO:    r_state <= S_DEC_WAIT;
            S_DEC_WAIT: begin
               if (bus.dec_done) begin
                  if (bus.dec_ok) begin
                     r_found <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_FOUND;
                  end else if (r_key == KEY_MAX) begin
                     r_fail  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_FAIL;
                  end else begin
                     r_state <= S_NEXT_KEY;
                  end
               end
            end
            S_NEXT_KEY: begin
               r_key        <= r_key + KEY_W'(1);
               r_init_start <= 1'b1;
               r_state      <= S_INIT_GO;
            end
            default:     r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_owned = 1'b1;
      w_addr  = bus.init_addr;
      w_data  = bus.init_data;
      w_wren  = bus.init_wren;
      case (r_state)
         S_INIT_GO, S_INIT_WAIT: begin
            w_owned = 1'b1;
         end
         S_KSA_GO, S_KSA_WAIT: begin
            w_addr = bus.ksa_addr;
            w_data = bus.ksa_data;
            w_wren = bus.ksa_wren;
         end
         S_DEC_GO, S_DEC_WAIT: begin
            w_addr = bus.dec_addr;
            w_data = bus.dec_data;
            w_wren = bus.dec_wren;
         end
         default: w_owned = 1'b0;
      endcase
   end

   // Unowned states keep addr/data and only squash the write enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_addr <= 8'd0;
         r_mem_data <= 8'd0;
         r_mem_wren <= 1'b0;
      end else if (w_owned) begin
         r_mem_addr <= w_addr;
         r_mem_data <= w_data;
         r_mem_wren <= w_wren;
      end else begin
         r_mem_wren <= 1'b0;
      end
   end

   assign bus.key        = r_key;
   assign bus.init_start = r_init_start;
   assign bus.ksa_start  = r_ksa_start;
   assign bus.dec_start  = r_dec_start;
   assign bus.busy       = r_busy;
   assign bus.found      = r_found;
   assign bus.fail       = r_fail;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_data   = r_mem_data;
   assign bus.mem_wren   = r_mem_wren;

endmodule

`default_nettype wire

// File: tb/tb_rc4_phase_scheduler.sv
//------------------------------------------------------------------------------
// Module : tb_rc4_phase_scheduler
// Brief  : Directed bench with behavioural init/KSA/decrypt engines and a memory-bus checker.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rc4_phase_scheduler;

   localparam int               KEY_W   = 24;
   localparam logic [KEY_W-1:0] KEY_MAX = 24'd3;
   localparam int               SEQ_WR  = 256 + 768 + 32;
   localparam int               LIM     = 8000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic go    = 1'b0;
   logic ok_en = 1'b0;
   logic [KEY_W-1:0] ok_key = '0;

   int checks   = 0;
   int failures = 0;

   logic       e_done [3];
   logic       e_wren [3];
   logic       e_force[3];
   logic       e_run  [3];
   logic [7:0] e_addr [3];
   logic [7:0] e_data [3];
   int         e_cnt  [3];
   int         st_cnt [3];
   int         wr_cnt;
   int         phase;
   int         nxt;
   logic       st_now;
   logic       exp_wren;
   logic [7:0] exp_addr, exp_data;

   rc4_phase_scheduler_if #(.KEY_W(KEY_W)) bus ();

   rc4_phase_scheduler #(
      .KEY_W    (KEY_W),
      .KEY_MAX  (KEY_MAX),
      .KEY_START(24'd0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.go        = go;
   assign bus.init_done = e_done[0];
   assign bus.ksa_done  = e_done[1];
   assign bus.dec_done  = e_done[2];
   assign bus.init_wren = e_wren[0] | e_force[0];
   assign bus.ksa_wren  = e_wren[1] | e_force[1];
   assign bus.dec_wren  = e_wren[2] | e_force[2];
   assign bus.init_addr = e_addr[0];
   assign bus.ksa_addr  = e_addr[1];
   assign bus.dec_addr  = e_addr[2];
   assign bus.init_data = e_data[0];
   assign bus.ksa_data  = e_data[1];
   assign bus.dec_data  = e_data[2];
   assign bus.dec_ok    = ok_en && (bus.key == ok_key);

   function automatic int eng_n(input int e);
      return (e == 0) ? 256 : (e == 1) ? 768 : 32;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Engines: on a start they keep done one more edge, then write N cycles and raise done.
   initial begin
      for (int e = 0; e < 3; e++) begin
         e_done[e] = 1'b0; e_wren[e] = 1'b0; e_force[e] = 1'b0; e_run[e] = 1'b0;
         e_addr[e] = 8'd0; e_data[e] = 8'd0; e_cnt[e] = 0; st_cnt[e] = 0;
      end
      wr_cnt = 0; phase = 3; nxt = 0;
      exp_wren = 1'b0; exp_addr = 8'd0; exp_data = 8'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int e = 0; e < 3; e++) begin
               e_run[e] = 1'b0; e_wren[e] = 1'b0; e_done[e] = 1'b0; e_cnt[e] = 0;
            end
            phase = 3; nxt = 0; exp_wren = 1'b0;
         end else begin
            chk("mem_wren", {31'd0, bus.mem_wren}, {31'd0, exp_wren});
            if (exp_wren) begin
               chk("mem_addr", {24'd0, bus.mem_addr}, {24'd0, exp_addr});
               chk("mem_data", {24'd0, bus.mem_data}, {24'd0, exp_data});
            end
            if (bus.mem_wren) wr_cnt++;
            for (int e = 0; e < 3; e++) begin
               st_now = (e == 0) ? bus.init_start : (e == 1) ? bus.ksa_start : bus.dec_start;
               if (st_now) begin
                  chk("start_order", e, nxt);
                  nxt = (e + 1) % 3;
                  phase = e;
                  st_cnt[e]++;
                  e_run[e] = 1'b1;
                  e_cnt[e] = eng_n(e);
               end else if (e_run[e]) begin
                  e_done[e] = 1'b0;
                  if (e_cnt[e] != 0) begin
                     e_wren[e] = 1'b1;
                     e_addr[e] = 8'(eng_n(e) - e_cnt[e]);
                     e_data[e] = 8'((eng_n(e) - e_cnt[e]) * 3 + e * 64 + 7);
                     e_cnt[e]--;
                  end else begin
                     e_wren[e] = 1'b0;
                     e_done[e] = 1'b1;
                     e_run[e]  = 1'b0;
                  end
               end
            end
            if (phase < 3) begin
               exp_wren = e_wren[phase] | e_force[phase];
               exp_addr = e_addr[phase];
               exp_data = e_data[phase];
            end else begin
               exp_wren = 1'b0;
            end
         end
      end
   end

   task automatic pulse_go();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic clr_counts();
      for (int e = 0; e < 3; e++) st_cnt[e] = 0;
      wr_cnt = 0;
   endtask

   task automatic wait_start(input int e, input int target, input string tag);
      int n = 0;
      while (st_cnt[e] < target && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, st_cnt[e] >= target}, 32'd1);
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!bus.found && !bus.fail && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, bus.found | bus.fail}, 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_key",    bus.key, 32'd0);
      chk("rst_flags",  {29'd0, bus.busy, bus.found, bus.fail}, 32'd0);
      chk("rst_starts", {29'd0, bus.init_start, bus.ksa_start, bus.dec_start}, 32'd0);
      chk("rst_mem",    {15'd0, bus.mem_wren, bus.mem_addr, bus.mem_data}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Key 0 decrypts on the first pass
      ok_en = 1'b1; ok_key = 24'd0;
      clr_counts();
      pulse_go();
      chk("a_busy", {31'd0, bus.busy}, 32'd1);
      wait_end("a_timeout");
      chk("a_found", {30'd0, bus.found, bus.fail}, 32'd2);
      chk("a_busy_end", {31'd0, bus.busy}, 32'd0);
      chk("a_key", bus.key, 32'd0);
      chk("a_starts", {8'd0, 8'(st_cnt[0]), 8'(st_cnt[1]), 8'(st_cnt[2])}, 32'h00010101);
      chk("a_writes", wr_cnt, SEQ_WR);

      // go after FOUND restarts; go during DEC_WAIT is ignored; key 3 succeeds
      ok_key = 24'd3;
      clr_counts();
      pulse_go();
      chk("b_restart", {bus.key[23:0], 5'd0, bus.busy, bus.found, bus.fail}, 32'h00000004);
      wait_start(2, 1, "b_dec_start");
      repeat (5) @(negedge clk);
      pulse_go();
      chk("b_go_ignored", {bus.key[23:0], 7'd0, bus.busy}, 32'h00000001);
      wait_end("b_timeout");
      chk("b_found", {30'd0, bus.found, bus.fail}, 32'd2);
      chk("b_key", bus.key, 32'd3);
      chk("b_starts", {8'd0, 8'(st_cnt[0]), 8'(st_cnt[1]), 8'(st_cnt[2])}, 32'h00040404);
      chk("b_writes", wr_cnt, 4 * SEQ_WR);

      // Key space exhausted
      ok_en = 1'b0;
      clr_counts();
      pulse_go();
      wait_end("c_timeout");
      chk("c_fail", {29'd0, bus.busy, bus.found, bus.fail}, 32'd1);
      chk("c_key", bus.key, 32'd3);
      chk("c_starts", {8'd0, 8'(st_cnt[0]), 8'(st_cnt[1]), 8'(st_cnt[2])}, 32'h00040404);
      repeat (40) @(negedge clk);
      chk("c_no_more_starts", st_cnt[0] + st_cnt[1] + st_cnt[2], 32'd12);
      chk("c_fail_sticky", {31'd0, bus.fail}, 32'd1);

      // Non-owner writes are squashed; stale init_done must not skip INIT_WAIT
      ok_en = 1'b1; ok_key = 24'd0;
      clr_counts();
      pulse_go();
      repeat (3) @(negedge clk);
      e_force[1] = 1'b1; e_force[2] = 1'b1;
      for (int n = 0; n < LIM && e_cnt[0] >= 8; n++) @(negedge clk);
      e_force[1] = 1'b0; e_force[2] = 1'b0;
      wait_end("d_timeout");
      chk("d_found", {bus.key[23:0], 6'd0, bus.found, bus.fail}, 32'd2);
      chk("d_starts", {8'd0, 8'(st_cnt[0]), 8'(st_cnt[1]), 8'(st_cnt[2])}, 32'h00010101);
      chk("d_writes", wr_cnt, SEQ_WR);

      // Async reset while KSA of key 1 is writing
      ok_key = 24'd2;
      clr_counts();
      pulse_go();
      wait_start(1, 2, "e_ksa_start");
      repeat (10) @(negedge clk);
      chk("e_pre_wren", {31'd0, bus.mem_wren}, 32'd1);
      chk("e_pre_key", bus.key, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("e_rst_wren", {31'd0, bus.mem_wren}, 32'd0);
      chk("e_rst_state", {bus.key[23:0], 5'd0, bus.busy, bus.found, bus.fail}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clr_counts();
      repeat (20) @(negedge clk);
      chk("e_no_starts", st_cnt[0] + st_cnt[1] + st_cnt[2], 32'd0);
      ok_key = 24'd0;
      pulse_go();
      wait_end("e_timeout");
      chk("e_refound", {bus.key[23:0], 6'd0, bus.found, bus.fail}, 32'd2);
      chk("e_starts", {8'd0, 8'(st_cnt[0]), 8'(st_cnt[1]), 8'(st_cnt[2])}, 32'h00010101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
